// File: rtl/clean_beats_ram_arbiter_pkg.sv
// Shared types and default widths for the two-master on-chip RAM arbiter.
package clean_beats_ram_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_t;

   localparam int unsigned DEF_ADDR_W = 10;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_BE_W   = DEF_DATA_W / 8;
   localparam int unsigned HOLD_CNT_W = 4;

endpackage

// File: rtl/clean_beats_ram_arbiter_if.sv
// Avalon-MM pipelined bus with waitrequest and readdatavalid; one instance per master.
interface clean_beats_ram_arbiter_if
   import clean_beats_ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned BE_W   = DEF_BE_W
);
   logic [ADDR_W-1:0] address;
   logic [BE_W-1:0]   byteenable;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/clean_beats_ram_arbiter_rr_grant2.sv
// Two-way round-robin grant with a bounded hold: the last owner keeps the port
// for up to HOLD_MAX consecutive beats while the other master is waiting.
module clean_beats_rr_grant2
   import clean_beats_ram_arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);
   localparam logic [HOLD_CNT_W-1:0] HOLD_LIM = HOLD_CNT_W'(HOLD_MAX - 1);

   owner_t                owner_q, owner_d;
   logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   owner_t                winner;

   always_comb begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      winner     = OWN_NONE;
      owner_d    = owner_q;
      hold_cnt_d = hold_cnt_q;
      if (!reset) begin
         if (req0 && !req1) begin
            gnt0 = 1'b1;
         end else if (req1 && !req0) begin
            gnt1 = 1'b1;
         end else if (req0 && req1) begin
            // Contention: owner keeps the port until its hold budget runs out.
            case (owner_q)
               OWN_M0:  if (hold_cnt_q < HOLD_LIM) gnt0 = 1'b1; else gnt1 = 1'b1;
               OWN_M1:  if (hold_cnt_q < HOLD_LIM) gnt1 = 1'b1; else gnt0 = 1'b1;
               default: gnt0 = 1'b1;
            endcase
         end
         if (gnt0 || gnt1) begin
            winner  = gnt0 ? OWN_M0 : OWN_M1;
            owner_d = winner;
            if (winner == owner_q)
               hold_cnt_d = (hold_cnt_q < HOLD_LIM) ? hold_cnt_q + HOLD_CNT_W'(1) : HOLD_LIM;
            else
               hold_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q    <= OWN_NONE;
         hold_cnt_q <= '0;
      end else begin
         owner_q    <= owner_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

endmodule

// File: rtl/clean_beats_ram_arbiter.sv
// Shares one single-port RAM (registered address, unregistered data) between the
// CPU data master (m0) and the audio DMA (m1); reads return one cycle after accept.
module clean_beats_ram_arbiter
   import clean_beats_ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned BE_W     = DEF_BE_W,
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   clean_beats_ram_arbiter_if.slave m0,
   clean_beats_ram_arbiter_if.slave m1,
   output logic [ADDR_W-1:0]     ram_address,
   output logic [BE_W-1:0]       ram_byteenable,
   output logic                  ram_chipselect,
   output logic                  ram_write,
   output logic [DATA_W-1:0]     ram_writedata,
   output logic                  ram_clken,
   input  logic [DATA_W-1:0]     ram_readdata
);
   logic gnt0, gnt1;
   logic rd_pend_q, rd_pend_d;
   logic rd_id_q, rd_id_d;

   clean_beats_rr_grant2 #(
      .HOLD_MAX (HOLD_MAX)
   ) u_grant (
      .clk   (clk),
      .reset (reset),
      .req0  (m0.read | m0.write),
      .req1  (m1.read | m1.write),
      .gnt0  (gnt0),
      .gnt1  (gnt1)
   );

   always_comb begin
      ram_address    = '0;
      ram_byteenable = '0;
      ram_writedata  = '0;
      ram_chipselect = 1'b0;
      ram_write      = 1'b0;
      if (gnt0) begin
         ram_address    = m0.address;
         ram_byteenable = m0.write ? m0.byteenable : '1;
         ram_writedata  = m0.writedata;
         ram_chipselect = 1'b1;
         ram_write      = m0.write;
      end else if (gnt1) begin
         ram_address    = m1.address;
         ram_byteenable = m1.write ? m1.byteenable : '1;
         ram_writedata  = m1.writedata;
         ram_chipselect = 1'b1;
         ram_write      = m1.write;
      end
   end

   // A simultaneous read+write is serviced as the write, so no return is queued.
   always_comb begin
      rd_pend_d = (gnt0 & m0.read & ~m0.write) | (gnt1 & m1.read & ~m1.write);
      rd_id_d   = gnt1;
   end

   always_ff @(posedge clk) begin
      if (reset) rd_pend_q <= 1'b0;
      else       rd_pend_q <= rd_pend_d;
      rd_id_q <= rd_id_d;
   end

   // Gating with reset drops the return of a read accepted just before reset rose.
   assign m0.waitrequest   = ~gnt0;
   assign m1.waitrequest   = ~gnt1;
   assign m0.readdata      = ram_readdata;
   assign m1.readdata      = ram_readdata;
   assign m0.readdatavalid = rd_pend_q & ~rd_id_q & ~reset;
   assign m1.readdatavalid = rd_pend_q &  rd_id_q & ~reset;
   assign ram_clken        = 1'b1;

endmodule

// File: tb/tb_clean_beats_ram_arbiter.sv
// Directed bench for clean_beats_ram_arbiter with a behavioural 1024x32 RAM whose
// unwritten words read as 0x5A000000 | address.
module tb_clean_beats_ram_arbiter;
   import clean_beats_ram_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect;
   logic        ram_write;
   logic [31:0] ram_writedata;
   logic        ram_clken;
   logic [31:0] ram_readdata;

   int n_checks = 0;
   int n_fail   = 0;

   clean_beats_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) m0_if ();
   clean_beats_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) m1_if ();

   clean_beats_ram_arbiter #(
      .ADDR_W(10), .DATA_W(32), .BE_W(4), .HOLD_MAX(4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .m0             (m0_if),
      .m1             (m1_if),
      .ram_address    (ram_address),
      .ram_byteenable (ram_byteenable),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_writedata  (ram_writedata),
      .ram_clken      (ram_clken),
      .ram_readdata   (ram_readdata)
   );

   always #5 clk = ~clk;

   // RAM model: registered address, combinational read of the addressed word.
   logic [31:0] mem [0:1023];
   logic [9:0]  ram_addr_q = '0;
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h5A00_0000 | 32'(i);
      end else if (ram_chipselect) begin
         ram_addr_q <= ram_address;
         if (ram_write)
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end
   end
   assign ram_readdata = mem[ram_addr_q];

   always @(posedge clk) begin
      if (!reset) begin
         assert (!(m0_if.read && m0_if.write)) else $error("illegal m0 read+write together");
         assert (!(m1_if.read && m1_if.write)) else $error("illegal m1 read+write together");
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_masters();
      m0_if.read = 1'b0; m0_if.write = 1'b0;
      m1_if.read = 1'b0; m1_if.write = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      m0_if.read = 1'b1; m0_if.write = 1'b0; m0_if.address = 10'h100;
      m0_if.byteenable = 4'hF; m0_if.writedata = '0;
      m1_if.read = 1'b1; m1_if.write = 1'b0; m1_if.address = 10'h200;
      m1_if.byteenable = 4'hF; m1_if.writedata = '0;
      for (int c = 0; c < 3; c++) begin
         step();
         n_checks++; if (m0_if.waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_m0_wait cyc%0d got %b exp 1", c, m0_if.waitrequest); end
         n_checks++; if (m1_if.waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_m1_wait cyc%0d got %b exp 1", c, m1_if.waitrequest); end
         n_checks++; if (ram_chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_cs cyc%0d got %b exp 0", c, ram_chipselect); end
         n_checks++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rdv cyc%0d got %b exp 00", c, {m0_if.readdatavalid, m1_if.readdatavalid}); end
      end
      n_checks++; if (ram_clken !== 1'b1) begin n_fail++; $display("FAIL clken got %b exp 1", ram_clken); end
      reset = 1'b0;
      #1;
      n_checks++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b01) begin n_fail++; $display("FAIL post_rst_grant got %b exp 01", {m0_if.waitrequest, m1_if.waitrequest}); end
      n_checks++; if (ram_chipselect !== 1'b1 || ram_address !== 10'h100) begin n_fail++; $display("FAIL post_rst_ram cs=%b addr=%h exp cs=1 addr=100", ram_chipselect, ram_address); end
      step();
      idle_masters();
      #1;
      n_checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'h5A00_0100) begin n_fail++; $display("FAIL post_rst_read rdv=%b data=%h exp 1/5a000100", m0_if.readdatavalid, m0_if.readdata); end
      step();
   endtask

   task automatic test_write_read();
      m0_if.write = 1'b1; m0_if.address = 10'h010; m0_if.writedata = 32'hDEAD_BEEF; m0_if.byteenable = 4'hF;
      #1;
      n_checks++; if (m0_if.waitrequest !== 1'b0 || ram_write !== 1'b1) begin n_fail++; $display("FAIL wr_accept wait=%b ram_write=%b exp 0/1", m0_if.waitrequest, ram_write); end
      step();
      m0_if.write = 1'b0; m0_if.read = 1'b1;
      #1;
      n_checks++; if (m0_if.waitrequest !== 1'b0 || ram_write !== 1'b0 || ram_byteenable !== 4'hF) begin n_fail++; $display("FAIL rd_accept wait=%b wr=%b be=%h exp 0/0/f", m0_if.waitrequest, ram_write, ram_byteenable); end
      n_checks++; if (m0_if.readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rdv_early got %b exp 0", m0_if.readdatavalid); end
      step();
      m0_if.read = 1'b0;
      #1;
      n_checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rd_data rdv=%b data=%h exp 1/deadbeef", m0_if.readdatavalid, m0_if.readdata); end
      n_checks++; if (m1_if.readdatavalid !== 1'b0) begin n_fail++; $display("FAIL m1_rdv_quiet got %b exp 0", m1_if.readdatavalid); end
      step();
      n_checks++; if (m0_if.readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rdv_single got %b exp 0", m0_if.readdatavalid); end
   endtask

   task automatic test_byteenable();
      m0_if.write = 1'b1; m0_if.address = 10'h020; m0_if.writedata = 32'h1122_3344; m0_if.byteenable = 4'hF;
      step();
      m0_if.writedata = 32'h0000_00AA; m0_if.byteenable = 4'h1;
      #1;
      n_checks++; if (ram_byteenable !== 4'h1) begin n_fail++; $display("FAIL be_drive got %h exp 1", ram_byteenable); end
      step();
      m0_if.write = 1'b0; m0_if.read = 1'b1;
      step();
      m0_if.read = 1'b0;
      #1;
      n_checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'h1122_33AA) begin n_fail++; $display("FAIL be_merge rdv=%b data=%h exp 1/112233aa", m0_if.readdatavalid, m0_if.readdata); end
      step();
   endtask

   // M0 has just taken several beats in a row, so its hold budget is spent:
   // contention hands the port to M1 first.
   task automatic test_round_robin();
      logic exp1, prev1;
      prev1 = 1'b0;
      m0_if.read = 1'b1; m0_if.address = 10'h100;
      m1_if.read = 1'b1; m1_if.address = 10'h200;
      for (int i = 0; i < 12; i++) begin
         exp1 = (i < 4) || (i >= 8);
         #1;
         n_checks++; if ({m0_if.waitrequest, m1_if.waitrequest} !== {exp1, ~exp1}) begin n_fail++; $display("FAIL rr_grant beat%0d wait m0m1=%b exp %b", i, {m0_if.waitrequest, m1_if.waitrequest}, {exp1, ~exp1}); end
         if (i > 0) begin
            n_checks++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== {~prev1, prev1} || m0_if.readdata !== (prev1 ? 32'h5A00_0200 : 32'h5A00_0100)) begin n_fail++; $display("FAIL rr_return beat%0d rdv=%b data=%h", i, {m0_if.readdatavalid, m1_if.readdatavalid}, m0_if.readdata); end
         end
         prev1 = exp1;
         step();
      end
      idle_masters();
      #1;
      n_checks++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b01 || m1_if.readdata !== 32'h5A00_0200) begin n_fail++; $display("FAIL rr_last rdv=%b data=%h exp 01/5a000200", {m0_if.readdatavalid, m1_if.readdatavalid}, m1_if.readdata); end
      step();
   endtask

   task automatic test_back_to_back();
      logic [9:0] a;
      logic [9:0] prev_a;
      prev_a = '0;
      m1_if.read = 1'b1;
      for (int i = 0; i < 10; i++) begin
         a = 10'h3F7 + 10'(i);
         m1_if.address = a;
         #1;
         n_checks++; if (m1_if.waitrequest !== 1'b0) begin n_fail++; $display("FAIL b2b_wait beat%0d got %b exp 0", i, m1_if.waitrequest); end
         if (i > 0) begin
            n_checks++; if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== (32'h5A00_0000 | 32'(prev_a))) begin n_fail++; $display("FAIL b2b_data beat%0d rdv=%b data=%h exp 1/%h", i, m1_if.readdatavalid, m1_if.readdata, 32'h5A00_0000 | 32'(prev_a)); end
         end
         prev_a = a;
         step();
      end
      m1_if.read = 1'b0;
      #1;
      n_checks++; if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== 32'h5A00_0000) begin n_fail++; $display("FAIL b2b_wrap rdv=%b data=%h exp 1/5a000000", m1_if.readdatavalid, m1_if.readdata); end
      step();
      n_checks++; if (m1_if.readdatavalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end rdv=%b exp 0", m1_if.readdatavalid); end
   endtask

   task automatic test_reset_after_read();
      m0_if.read = 1'b1; m0_if.address = 10'h100;
      #1;
      n_checks++; if (m0_if.waitrequest !== 1'b0) begin n_fail++; $display("FAIL rr_pre_wait got %b exp 0", m0_if.waitrequest); end
      step();
      m0_if.read = 1'b0;
      reset = 1'b1;
      #1;
      n_checks++; if (m0_if.readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rst_suppress rdv=%b exp 0", m0_if.readdatavalid); end
      n_checks++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b11) begin n_fail++; $display("FAIL rst_wait got %b exp 11", {m0_if.waitrequest, m1_if.waitrequest}); end
      step();
      reset = 1'b0;
      #1;
      n_checks++; if (dut.u_grant.owner_q !== OWN_NONE) begin n_fail++; $display("FAIL rst_owner got %0d exp %0d", dut.u_grant.owner_q, OWN_NONE); end
      n_checks++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rdv_after got %b exp 00", {m0_if.readdatavalid, m1_if.readdatavalid}); end
      m0_if.read = 1'b1; m1_if.read = 1'b1;
      #1;
      n_checks++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b01) begin n_fail++; $display("FAIL rst_regrant got %b exp 01", {m0_if.waitrequest, m1_if.waitrequest}); end
      step();
      idle_masters();
      step();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byteenable();
      test_round_robin();
      test_back_to_back();
      test_reset_after_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
